// File: rtl/handshake_initiator.sv
// ---------------------------------------------------------------------------
// handshake_initiator
//
// Initiating end of a four-phase req/ack handshake. A local producer hands
// over one word at a time on a valid/ready port. The word is driven on
// data_out and the block walks the cycle req rise, ack rise, req fall,
// ack fall. The block pulses done when a cycle completes cleanly. If the
// responder stalls in any phase, the block abandons the cycle and raises a
// sticky timeout_err.
//
// Parameters
//   DATA_W      width of in_data / data_out
//   SYNC_STAGES flops in the ack synchroniser (1..4)
//   TIMEOUT     max cycles spent in one handshake phase, 0 = never time out
//
// Ports
//   clk          rising-edge clock for all logic
//   rst          synchronous, active-high reset
//   in_valid     producer offers a word
//   in_ready     block can take a word this cycle (combinational)
//   in_data      producer word
//   req          handshake request to the responder (registered)
//   data_out     word presented to the responder (registered, held)
//   ack          handshake acknowledge, asynchronous to clk
//   busy         a transaction is in flight
//   done         one-cycle pulse, transaction finished without timeout
//   err_clr      clears timeout_err
//   timeout_err  sticky, some handshake phase timed out
// ---------------------------------------------------------------------------
module handshake_initiator #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              req,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    input  logic              err_clr,
    output logic              timeout_err
);

    // The phase timer only has to reach TIMEOUT-1, so it needs
    // clog2(TIMEOUT) bits. It is never narrower than one bit.
    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        (TIMEOUT > 0) ? TIMER_W'(TIMEOUT - 1) : '0;

    // Two-bit state code. The spare code 2'b11 is caught by the default arm.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic                 aborted;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                 ack_s;
    logic                 timer_expired;

    // -----------------------------------------------------------------------
    // ack synchroniser. The FSM only ever looks at the last stage.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the value its neighbour held before this edge.
            ack_sync[0] <= ack;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ack_sync[i] <= ack_sync[i-1];
            end
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // A phase ends on this edge when the timer already holds TIMEOUT-1,
    // so a phase lasts at most TIMEOUT edges.
    assign timer_expired = TIMEOUT_EN && (timer == TIMER_LAST);

    // -----------------------------------------------------------------------
    // Combinational handshake-side outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and infers a latch.
        in_ready = 1'b0;
        if (state == ST_IDLE) begin
            // Do not start a new cycle until the responder has let go of
            // ack from the previous one (or from a stuck responder).
            in_ready = !ack_s;
        end
    end

    assign busy = (state != ST_IDLE);

    // -----------------------------------------------------------------------
    // Handshake FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req         <= 1'b0;
            data_out    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            timer       <= '0;
            aborted     <= 1'b0;
        end else begin
            done <= 1'b0;

            // NOTE: the clear comes before the FSM, so a timeout set
            // further down on the same edge overrides it. The last
            // non-blocking assignment wins.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        data_out <= in_data;
                        req      <= 1'b1;
                        timer    <= '0;
                        aborted  <= 1'b0;
                        state    <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (ack_s) begin
                        req   <= 1'b0;
                        timer <= '0;
                        state <= ST_RELEASE;
                    end else if (timer_expired) begin
                        // Withdraw the request and still wait for ack to be
                        // low. The aborted flag suppresses done at the end.
                        req         <= 1'b0;
                        timeout_err <= 1'b1;
                        aborted     <= 1'b1;
                        timer       <= '0;
                        state       <= ST_RELEASE;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (!ack_s) begin
                        done  <= !aborted;
                        state <= ST_IDLE;
                    end else if (timer_expired) begin
                        // The responder is holding ack high. Give up. IDLE
                        // keeps in_ready low until ack actually falls.
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    req   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_initiator.sv
// ---------------------------------------------------------------------------
// tb_handshake_initiator
//
// Directed bench for handshake_initiator (DATA_W=8, SYNC_STAGES=2,
// TIMEOUT=16). The responder either loops req back as ack one cycle later,
// or the bench drives ack directly. Inputs change 1 ns after each rising
// edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_handshake_initiator;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic [DATA_W-1:0] data_out;
    logic              ack;
    logic              busy;
    logic              done;
    logic              err_clr;
    logic              timeout_err;

    // Responder: 0 = loopback (ack = req registered once), 1 = forced level.
    logic ack_mode  = 1'b0;
    logic ack_force = 1'b0;
    logic ack_reg   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ack_reg <= req;
    assign ack = ack_mode ? ack_force : ack_reg;

    handshake_initiator #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .req        (req),
        .data_out   (data_out),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .err_clr    (err_clr),
        .timeout_err(timeout_err)
    );

    // One table row = inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        e_req;
        logic        e_rdy;
        logic        e_busy;
        logic        e_done;
        logic [7:0]  e_dout;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic vld, input logic [7:0] data,
                                input logic e_req, input logic e_rdy,
                                input logic e_busy, input logic e_done,
                                input logic [7:0] e_dout);
        vec_t v;
        v.vld = vld; v.data = data; v.e_req = e_req; v.e_rdy = e_rdy;
        v.e_busy = e_busy; v.e_done = e_done; v.e_dout = e_dout;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {req, in_ready, busy, done, timeout_err, data_out}
    function automatic logic [12:0] outs();
        return {req, in_ready, busy, done, timeout_err, data_out};
    endfunction

    logic [7:0] words[3];

    initial begin
        begin : watchdog
            fork
                begin
                    #500000;
                    $display("FAIL watchdog: got timeout expected finish");
                    $fatal(1, "bench did not finish");
                end
            join_none
        end

        // Loopback timing of one word, 0xA5, accepted at edge T (row 0).
        // Bytes offered while not ready (0xFF) must not be captured.
        tbl[0] = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[1] = mk(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[2] = mk(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[3] = mk(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[4] = mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[5] = mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[6] = mk(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[7] = mk(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[8] = mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
        tbl[9] = mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);

        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        // Expected after reset: req=0, in_ready=1, busy=0, done=0,
        // timeout_err=0, data_out=0.
        check("reset_outputs", 32'(outs()), 32'(13'b0_1_0_0_0_00000000));

        // ---- single word, table driven ----------------------------------
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].vld;
            in_data  = tbl[i].data;
            tick();
            check($sformatf("single_word_row%0d", i), 32'(outs()),
                  32'({tbl[i].e_req, tbl[i].e_rdy, tbl[i].e_busy,
                       tbl[i].e_done, 1'b0, tbl[i].e_dout}));
        end
        in_valid = 1'b0;

        // ---- back-to-back words, in_valid held while any remain ---------
        begin
            int idx = 0;
            int n_done = 0;
            for (int c = 0; c < 27; c++) begin
                logic acc;
                in_valid = (idx < 3);
                in_data  = (idx < 3) ? words[idx] : 8'hEE;
                acc = in_valid && in_ready;
                tick();
                if (acc) idx++;
                if (done) n_done++;
                check($sformatf("b2b_done_c%0d", c), 32'(done),
                      32'((c % 9) == 8));
                check($sformatf("b2b_dout_c%0d", c), 32'(data_out),
                      32'(words[c / 9]));
            end
            in_valid = 1'b0;
            check("b2b_done_count", 32'(n_done), 32'd3);
            check("b2b_words_taken", 32'(idx), 32'd3);
        end

        // ---- REQ phase timeout, ack held low ----------------------------
        ack_mode = 1'b1; ack_force = 1'b0;
        begin
            int n_done = 0;
            in_valid = 1'b1; in_data = 8'h3C;
            tick();                                  // edge T
            in_valid = 1'b0;
            for (int k = 1; k <= 15; k++) begin
                tick();
                if (done) n_done++;
            end
            check("req_to_before", 32'({req, timeout_err}), 32'b10);
            tick();                                  // edge T+16
            if (done) n_done++;
            check("req_to_drop", 32'({req, timeout_err, busy}), 32'b011);
            tick();                                  // edge T+17
            if (done) n_done++;
            check("req_to_idle", 32'({busy, in_ready, timeout_err, data_out}),
                  32'({1'b0, 1'b1, 1'b1, 8'h3C}));
            check("req_to_no_done", 32'(n_done), 32'd0);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check("err_clr", 32'(timeout_err), 32'd0);
        end

        // ---- ack high while idle blocks acceptance ----------------------
        ack_force = 1'b1;
        tick();
        check("ack_hi_ready_lag", 32'(in_ready), 32'd1);
        tick();
        check("ack_hi_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_data = 8'h99;
        for (int k = 0; k < 4; k++) tick();
        check("ack_hi_no_accept", 32'({in_ready, busy, req, data_out}),
              32'({1'b0, 1'b0, 1'b0, 8'h3C}));
        in_valid = 1'b0; ack_force = 1'b0;
        tick();
        check("ack_rel_ready_1", 32'(in_ready), 32'd0);
        tick();
        check("ack_rel_ready_2", 32'(in_ready), 32'd1);

        // ---- RELEASE timeout with ack stuck high, set beats clear -------
        begin
            int n_done = 0;
            in_valid = 1'b1; in_data = 8'hC3;
            tick();                                  // edge T
            check("stuck_accept", 32'({req, data_out}), 32'({1'b1, 8'hC3}));
            in_valid = 1'b0; ack_force = 1'b1;
            tick(); tick();                          // T+1, T+2
            tick();                                  // T+3: enter RELEASE
            check("stuck_release", 32'({req, busy}), 32'b01);
            for (int k = 4; k <= 18; k++) begin
                tick();
                if (done) n_done++;
            end
            check("stuck_before_to", 32'({busy, timeout_err}), 32'b10);
            err_clr = 1'b1;
            tick();                                  // T+19: timeout + clear
            err_clr = 1'b0;
            if (done) n_done++;
            check("stuck_set_wins", 32'(timeout_err), 32'd1);
            check("stuck_idle", 32'({busy, in_ready, done}), 32'b000);
            check("stuck_no_done", 32'(n_done), 32'd0);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            in_valid = 1'b1; in_data = 8'h44;
            for (int k = 0; k < 20; k++) tick();
            check("stuck_idle_no_to",
                  32'({timeout_err, busy, in_ready, data_out}),
                  32'({1'b0, 1'b0, 1'b0, 8'hC3}));
            in_valid = 1'b0; ack_force = 1'b0;
            tick(); tick();
            check("stuck_ready_back", 32'(in_ready), 32'd1);
        end

        // ---- reset in the middle of REQ ---------------------------------
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("mid_rst_in_req", 32'({req, busy, data_out}),
              32'({1'b1, 1'b1, 8'h5A}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_outputs", 32'(outs()), 32'(13'b0_1_0_0_0_00000000));
        begin
            int n_done = 0;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (done) n_done++;
            end
            check("mid_rst_no_done", 32'(n_done), 32'd0);
        end
        ack_mode = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        for (int k = 0; k <= 9; k++) begin
            tick();                                  // k = 0 is edge T'
            in_valid = 1'b0;
            check($sformatf("post_rst_k%0d", k), 32'({req, done, data_out}),
                  32'({k <= 3, k == 8, 8'h77}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
